// File: rtl/gpio_switch_debounce_if.sv
// gpio_switch_debounce_if: switch levels in, debounced levels, edge pulses and sticky change flag out
interface gpio_switch_debounce_if #(
    parameter int WIDTH = 9
);
    logic [WIDTH-1:0] sw_raw_i;
    logic             clear_i;
    logic [WIDTH-1:0] sw_stable_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic             change_o;
    modport master (
        output sw_raw_i, clear_i,
        input  sw_stable_o, rise_o, fall_o, change_o
    );
    modport slave (
        input  sw_raw_i, clear_i,
        output sw_stable_o, rise_o, fall_o, change_o
    );
endinterface

// File: rtl/gpio_switch_debounce.sv
// gpio_switch_debounce: synchronizes and debounces each switch bit independently, flags accepted edges
module gpio_switch_debounce #(
    parameter int WIDTH           = 9,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input logic                   clk,
    input logic                   reset,
    gpio_switch_debounce_if.slave sw
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [WIDTH-1:0] s1_q, s2_q, stable_q, stable_d, rise_q, fall_q;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic             change_q, change_d;
    // A full count of disagreement both accepts the new level and rearms the counter.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i]    = (s2_q[i] == stable_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + CW'(1);
            stable_d[i] = (s2_q[i] != stable_q[i] && cnt_q[i] == LAST) ? s2_q[i] : stable_q[i];
        end
        change_d = (|{rise_q, fall_q}) | (change_q & ~sw.clear_i);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            cnt_q    <= '{default: '0};
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= 1'b0;
        end else begin
            s1_q     <= sw.sw_raw_i;
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= stable_d & ~stable_q;
            fall_q   <= ~stable_d & stable_q;
            change_q <= change_d;
        end
    end
    assign sw.sw_stable_o = stable_q;
    assign sw.rise_o      = rise_q;
    assign sw.fall_o      = fall_q;
    assign sw.change_o    = change_q;
    assert property (@(posedge clk) disable iff (!reset) (rise_q & fall_q) == '0);
endmodule

// File: doc/gpio_switch_debounce.md
GPIO_SWITCH_DEBOUNCE -- requirements
Module: gpio_switch_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 9: number of switch inputs conditioned.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive clk cycles a synchronized level must persist before acceptance (10 ms at 50 MHz); legal range 1..2^24.
REQ-003 SHALL have port clk, input, 1: system clock, all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port sw_raw_i, input, WIDTH: raw asynchronous board switch levels.
REQ-006 SHALL have port clear_i, input, 1: one-cycle pulse clearing the sticky change flag; driven by the bus write-strobe decode.
REQ-007 SHALL have port sw_stable_o, output, WIDTH: debounced switch levels; connects directly to the GPIO switch input port, which is read at 0x10010028.
REQ-008 SHALL have port rise_o, output, WIDTH: per-bit one-cycle pulse on accepted 0->1 transition.
REQ-009 SHALL have port fall_o, output, WIDTH: per-bit one-cycle pulse on accepted 1->0 transition.
REQ-010 SHALL have port change_o, output, 1: sticky flag, any bit accepted a transition since last clear.

Function
REQ-011 SHALL pass each sw_raw_i bit through a two-flop synchronizer (s1, then s2); only s2 is used downstream.
REQ-012 SHALL keep an independent counter per bit, width sufficient to hold DEBOUNCE_CYCLES-1, no wrap-around possible.
REQ-013 Per bit, each edge: if s2 == sw_stable_o, the counter SHALL load 0.
REQ-014 Per bit, each edge: if s2 != sw_stable_o and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-015 Per bit, each edge: if s2 != sw_stable_o and counter == DEBOUNCE_CYCLES-1, sw_stable_o SHALL load s2 and the counter SHALL load 0.
REQ-016 Latency: a raw level set up before edge k and held SHALL appear on sw_stable_o after edge k+DEBOUNCE_CYCLES+1; with DEBOUNCE_CYCLES=1, after edge k+2.
REQ-017 A mismatch interrupted before acceptance (glitch or bounce) SHALL restart the count from 0; sw_stable_o SHALL not change.
REQ-018 rise_o[i]/fall_o[i] SHALL be registered, asserted for exactly the one cycle following the edge at which sw_stable_o[i] changes, and SHALL never assert together for the same bit.
REQ-019 Bits SHALL be fully independent; simultaneous acceptances on several bits SHALL produce simultaneous pulses.
REQ-020 change_o SHALL set on the edge after any rise_o or fall_o bit is high, and SHALL clear on an edge where clear_i is high.
REQ-021 When set and clear_i coincide on the same edge, set SHALL win (change_o stays 1).
REQ-022 clear_i held high continuously SHALL keep change_o at 0 except on set edges, per REQ-021.
REQ-023 All outputs SHALL be registered; no combinational path from sw_raw_i or clear_i to any output.

Reset
REQ-024 While reset is low: s1, s2, all counters, sw_stable_o, rise_o, fall_o and change_o SHALL be 0, asynchronously.
REQ-025 Reset asserted mid-count SHALL abandon the count; no pulse or flag SHALL be produced by the interrupted transition.
REQ-026 A switch held at 1 through reset release SHALL be accepted as a normal 0->1 transition: sw_stable_o high after edge DEBOUNCE_CYCLES+2 post-release, with rise_o pulse and change_o set.

Verification (DEBOUNCE_CYCLES=4, WIDTH=9)
VER-001 Reset released, sw_raw_i=0x000 -> sw_stable_o=0x000, rise_o=fall_o=0, change_o=0 for 20 cycles.
VER-002 sw_raw_i bit0 0->1 before edge k, held -> sw_stable_o=0x001 after edge k+5, rise_o=0x001 for one cycle only, change_o=1 after edge k+6.
VER-003 bit3 bounces 1,0,1,0 (one cycle each) then holds 1 -> no change until 5 edges after final rise, then single rise_o=0x008; no fall_o.
VER-004 sw_raw_i 0x000->0x1FF in one cycle -> sw_stable_o=0x1FF on the same edge, rise_o=0x1FF one cycle; then clear_i pulse -> change_o=0.
VER-005 clear_i high on the same edge change_o would set -> change_o=1; clear_i next edge -> change_o=0.
VER-006 reset low 2 cycles in after a 0->1 on bit5 -> all outputs 0; after release with bit5 still 1 -> sw_stable_o=0x020 after edge 6 post-release, one rise_o pulse.
